// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : load/store sequencer for a req/gnt + rvalid data bus
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_en,
  input  logic                  mem_we,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  misaligned,
  output logic                  timeout_err,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_gnt,
  input  logic                  bus_rvalid,
  input  logic [DATA_WIDTH-1:0] bus_rdata
);

  localparam int                c_cnt_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {E_NONE, E_MIS, E_TO} err_t;

  state_t                  state_q, state_d;
  err_t                    err_q, err_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic                    legal;
  logic                    aligned;
  logic [3:0]              be_new;
  logic [DATA_WIDTH-1:0]   wdata_new;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic                    last_cycle;

  // Decode of the incoming request: legality, alignment, lanes, replicated data.
  always_comb begin
    legal     = 1'b0;
    aligned   = 1'b1;
    be_new    = 4'b0000;
    wdata_new = wdata;
    case (funct3)
      3'b000: begin
        legal     = 1'b1;
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      3'b001: begin
        legal     = 1'b1;
        aligned   = ~addr[0];
        be_new    = 4'b0011 << {addr[1], 1'b0};
        wdata_new = {2{wdata[15:0]}};
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (addr[1:0] == 2'b00);
        be_new  = 4'b1111;
      end
      3'b100: legal = ~mem_we;
      3'b101: begin
        legal   = ~mem_we;
        aligned = ~addr[0];
      end
      default: legal = 1'b0;
    endcase
    if (!mem_we) be_new = 4'b0000;
  end

  always_comb begin
    byte_sel = bus_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      2'd3:    byte_sel = bus_rdata[31:24];
      default: byte_sel = bus_rdata[7:0];
    endcase
    half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus_rdata;
    endcase
  end

  // A completing event in the last allowed cycle takes priority over the abort.
  assign last_cycle = (cnt_q >= c_last_cnt);

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_en) begin
          we_d     = mem_we;
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata_new;
          be_d     = be_new;
          cnt_d    = '0;
          if (legal && aligned) begin
            state_d = S_REQ;
            err_d   = E_NONE;
          end else begin
            state_d = S_DONE;
            err_d   = E_MIS;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + c_cnt_w'(1);
        if (bus_gnt) begin
          state_d = we_q ? S_DONE : S_WAIT;
        end else if (last_cycle) begin
          state_d = S_DONE;
          err_d   = E_TO;
          rdata_d = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + c_cnt_w'(1);
        if (bus_rvalid) begin
          state_d = S_DONE;
          rdata_d = load_ext;
        end else if (last_cycle) begin
          state_d = S_DONE;
          err_d   = E_TO;
          rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      err_q    <= E_NONE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 4'b0000;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
    end
  end

  assign stall       = ~rst & (((state_q == S_IDLE) & mem_en) |
                               (state_q == S_REQ) | (state_q == S_WAIT));
  assign rdata       = rdata_q;
  assign rdata_valid = (state_q == S_DONE) & (err_q == E_NONE) & ~we_q;
  assign misaligned  = (state_q == S_DONE) & (err_q == E_MIS);
  assign timeout_err = (state_q == S_DONE) & (err_q == E_TO);
  assign bus_req     = (state_q == S_REQ);
  assign bus_we      = we_q;
  assign bus_addr    = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign bus_wdata   = wdata_q;
  assign bus_be      = be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// tb_mem_access_ctrl : vector table, corner sequences and random ops vs model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst, mem_en, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, misaligned, timeout_err;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .misaligned(misaligned), .timeout_err(timeout_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          gd;      // REQ cycles before gnt
    int          rd;      // WAIT cycles before rvalid
    bit          stray;   // rvalid also driven (with junk) during REQ
    int          busy;    // expected stall cycles
    bit          rv, mis, to;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] word, input int gd,
                              input int rd, input bit stray, input int busy, input bit rv,
                              input bit mis, input bit to, input logic [31:0] rdat,
                              input logic [3:0] be, input logic [31:0] bwd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.word = word; v.gd = gd; v.rd = rd;
    v.stray = stray; v.busy = busy; v.rv = rv; v.mis = mis; v.to = to; v.rdata = rdat;
    v.be = be; v.bwdata = bwd;
    return v;
  endfunction

  // Reference: access size/sign from funct3, lanes as byte ranges, result by arithmetic.
  function automatic vec_t model(input vec_t i);
    vec_t   o;
    int     size, off, n;
    bit     sgn, legal, algn;
    longint val;
    o = i; size = 0; sgn = 1'b0; off = int'(i.addr[1:0]);
    case (i.f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: size = 4;
      3'd4: size = 1;
      3'd5: size = 2;
      default: size = 0;
    endcase
    legal = (size != 0) && !(i.we && i.f3[2]);
    algn  = legal && ((off % size) == 0);
    o.rv = 0; o.mis = 0; o.to = 0; o.rdata = '0; o.be = '0; o.bwdata = '0;
    if (!algn) begin
      o.mis = 1; o.busy = 1;
      return o;
    end
    for (int b = 0; b < 4; b++) begin
      if (i.we && b >= off && b < off + size) o.be[b] = 1'b1;
      o.bwdata[8*b +: 8] = i.wdata[8*(b % size) +: 8];
    end
    n = i.we ? i.gd + 1 : i.gd + i.rd + 2;
    if (n > T) begin
      o.to = 1; o.busy = 1 + T;
    end else begin
      o.busy = 1 + n;
      if (!i.we) begin
        val = longint'(i.word >> (8 * off)) & ((longint'(1) << (8 * size)) - 1);
        if (sgn && val[8*size-1]) val = val - (longint'(1) << (8 * size));
        o.rdata = val[31:0];
        o.rv = 1;
      end
    end
    return o;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_rvalid"}, 32'(rdata_valid), 32'd0);
    chk({tag, "_mis"}, 32'(misaligned), 32'd0);
    chk({tag, "_to"}, 32'(timeout_err), 32'd0);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_be"}, 32'(bus_be), 32'd0);
  endtask

  // Entered and left just after a rising edge; bus responder reacts to bus_req.
  task automatic run_op(input vec_t v, input string tag);
    int          busy = 0, req_seen = 0, wait_cnt = 0, n_rv = 0, n_mis = 0, n_to = 0;
    bit          granted = 0, req_ever = 0, done = 0;
    logic [31:0] rd_done = '0;
    mem_en = 1'b1; mem_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = ~v.word;
      if (bus_req) begin
        req_seen++;
        if (req_seen == v.gd + 1) bus_gnt = 1'b1;
        if (v.stray) bus_rvalid = 1'b1;
      end else if (granted) begin
        wait_cnt++;
        if (wait_cnt == v.rd + 1) begin
          bus_rvalid = 1'b1;
          bus_rdata  = v.word;
        end
      end
      if (bus_gnt && !v.we) granted = 1;
      @(negedge clk);
      if (rdata_valid) n_rv++;
      if (misaligned) n_mis++;
      if (timeout_err) n_to++;
      if (bus_req) begin
        req_ever = 1;
        chk({tag, "_bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
        chk({tag, "_bus_we"}, 32'(bus_we), 32'(v.we));
        chk({tag, "_bus_be"}, 32'(bus_be), 32'(v.be));
        chk({tag, "_bus_wdata"}, bus_wdata, v.bwdata);
      end
      if (stall) busy++;
      else begin
        done = 1;
        rd_done = rdata;
      end
      if (!done) begin
        @(posedge clk); #1;
      end
    end
    chk({tag, "_finished"}, 32'(done), 32'd1);
    @(posedge clk); #1;
    mem_en = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    if (rdata_valid) n_rv++;
    if (misaligned) n_mis++;
    if (timeout_err) n_to++;
    chk({tag, "_idle_stall"}, 32'(stall), 32'd0);
    chk({tag, "_stall_cycles"}, 32'(busy), 32'(v.busy));
    chk({tag, "_rvalid_pulses"}, 32'(n_rv), 32'(v.rv));
    chk({tag, "_mis_pulses"}, 32'(n_mis), 32'(v.mis));
    chk({tag, "_to_pulses"}, 32'(n_to), 32'(v.to));
    chk({tag, "_req_seen"}, 32'(req_ever), 32'(!v.mis));
    if (v.rv || v.to) chk({tag, "_rdata"}, rd_done, v.rdata);
    @(posedge clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        we f3    addr          wdata         word          gd rd st busy rv mis to rdata         be       bwdata
    tbl.push_back(mk(0, 3'd2, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1, 0, 4, 1, 0, 0, 32'hDEAD_BEEF, 4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 0, 0, 3, 1, 0, 0, 32'hFFFF_FF80, 4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 0, 0, 3, 1, 0, 0, 32'h0000_0080, 4'h0, 32'h0));
    tbl.push_back(mk(1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        3, 0, 0, 5, 0, 0, 0, 32'h0,         4'hC, 32'hABCD_ABCD));
    tbl.push_back(mk(0, 3'd2, 32'h0000_0101, 32'h0,        32'h0,         0, 0, 0, 1, 0, 1, 0, 32'h0,         4'h0, 32'h0));
    tbl.push_back(mk(1, 3'd3, 32'h0000_0100, 32'h55,       32'h0,         0, 0, 0, 1, 0, 1, 0, 32'h0,         4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h0000_0100, 32'h0,        32'h1234_5678, 20, 0, 0, 9, 0, 0, 1, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd1, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 0, 0, 4, 1, 0, 0, 32'hFFFF_8001, 4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd5, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 0, 0, 4, 1, 0, 0, 32'h0000_8001, 4'h0, 32'h0));
    tbl.push_back(mk(1, 3'd0, 32'h0000_0105, 32'h0000_00A5, 32'h0,        0, 0, 0, 2, 0, 0, 0, 32'h0,         4'h2, 32'hA5A5_A5A5));
    tbl.push_back(mk(1, 3'd2, 32'h0000_010C, 32'hCAFE_F00D, 32'h0,        1, 0, 0, 3, 0, 0, 0, 32'h0,         4'hF, 32'hCAFE_F00D));
    tbl.push_back(mk(0, 3'd6, 32'h0000_0100, 32'h0,        32'h0,         0, 0, 0, 1, 0, 1, 0, 32'h0,         4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd1, 32'h0000_0103, 32'h0,        32'h0,         0, 0, 0, 1, 0, 1, 0, 32'h0,         4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd2, 32'h0000_0100, 32'h0,        32'h7777_7777, 0, 10, 0, 9, 0, 0, 1, 32'h0,        4'h0, 32'h0));
    tbl.push_back(mk(1, 3'd2, 32'h0000_0300, 32'h0BAD_CAFE, 32'h0,        9, 0, 0, 9, 0, 0, 1, 32'h0,         4'hF, 32'h0BAD_CAFE));
    tbl.push_back(mk(0, 3'd2, 32'h0000_0104, 32'h0,        32'h1357_9BDF, 0, 6, 0, 9, 1, 0, 0, 32'h1357_9BDF, 4'h0, 32'h0));
    tbl.push_back(mk(1, 3'd0, 32'h0000_0101, 32'h0000_0077, 32'h0,        7, 0, 0, 9, 0, 0, 0, 32'h0,         4'h2, 32'h7777_7777));
    tbl.push_back(mk(0, 3'd2, 32'h0000_0108, 32'h0,        32'h0BAD_F00D, 1, 0, 1, 4, 1, 0, 0, 32'h0BAD_F00D, 4'h0, 32'h0));
    tbl.push_back(mk(0, 3'd0, 32'h0000_0100, 32'h0,        32'h0000_007F, 0, 0, 0, 3, 1, 0, 0, 32'h0000_007F, 4'h0, 32'h0));
    tbl.push_back(mk(1, 3'd1, 32'h0000_0200, 32'hFFFF_8765, 32'h0,        0, 0, 0, 2, 0, 0, 0, 32'h0,         4'h3, 32'h8765_8765));

    rst = 1'b1; mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'd2; addr = 32'h100; wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("reset_stall_forced", 32'(stall), 32'd0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; mem_en = 1'b0;

    // Stray bus responses while idle must be ignored.
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_stray_stall", 32'(stall), 32'd0);
      chk("idle_stray_req", 32'(bus_req), 32'd0);
      chk("idle_stray_rvalid", 32'(rdata_valid), 32'd0);
      @(posedge clk); #1;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0;

    for (int k = 0; k < tbl.size(); k++) run_op(tbl[k], $sformatf("vec%0d", k));

    // Reset while waiting for read data; the late response must be dropped.
    mem_en = 1'b1; mem_we = 1'b0; funct3 = 3'd2; addr = 32'h40; wdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_mid_req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    chk("rst_mid_wait_stall", 32'(stall), 32'd1);
    rst = 1'b1; mem_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall_forced", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    chk_all_zero("rst_mid_after");
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_no_pulse", 32'(rdata_valid), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    run_op(mk(0, 3'd2, 32'h0000_0040, 32'h0, 32'h600D_D00D, 0, 0, 0, 3, 1, 0, 0,
              32'h600D_D00D, 4'h0, 32'h0), "rst_mid_next");

    for (int k = 0; k < 60; k++) begin
      vec_t r;
      r = mk(0, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
      r.we    = 1'($urandom_range(0, 1));
      r.f3    = 3'($urandom_range(0, 7));
      r.addr  = $urandom;
      r.word  = $urandom;
      r.wdata = r.we ? $urandom : 32'h0;
      r.gd    = $urandom_range(0, 10);
      r.rd    = $urandom_range(0, 4);
      r.stray = 1'($urandom_range(0, 1));
      if (!r.we && r.gd == T - 1) r.gd = T - 2;
      run_op(model(r), $sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
